// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_if
//  Description : Control bundle between the multicycle MIPS main controller
//                and its shared-memory datapath.
//                master : controller side (drives selects/enables/state,
//                         samples op/funct/zero)
//                slave  : datapath side (drives op/funct/zero, samples the
//                         controls)
//  Signals     : op[5:0], funct[5:0], zero         datapath -> controller
//                iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//                alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_control[2:0],
//                pc_en, state[3:0]                 controller -> datapath
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic       pc_en;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, pc_en, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, pc_en, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Main control unit of the multicycle MIPS core. Moore FSM
//                stepping each instruction through fetch/decode/execute/
//                memory/writeback, plus the ALU decoder.
//  Ports       : clk        system clock, rising edge
//                rst        synchronous active-high reset
//                bus        mc_ctrl_if.master (op/funct/zero in, datapath
//                           selects, write enables, pc_en and state out)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl (
  input  wire logic   clk,
  input  wire logic   rst,
  mc_ctrl_if.master   bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_cur;
  state_t     w_next;

  logic       w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg;
  logic       w_reg_write, w_alu_src_a, w_pc_write, w_branch;
  logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;
  logic [2:0] w_alu_control;

  // While reset is held the outputs decode as if in FETCH (with the write
  // enables masked below), regardless of what the register currently holds.
  assign w_cur = rst ? S_FETCH : r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    case (w_cur)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_alu_src_b = 2'b01;
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_ADDI:        w_next = S_ADDIEX;
          c_OP_J:           w_next = S_JUMP;
          default:          w_next = S_FETCH;  // unknown op retires as a NOP
        endcase
      end
      S_MEMADR: begin
        w_next      = (bus.op == c_OP_LW) ? S_MEMRD : S_MEMWR;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_next = S_MEMWB;
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        w_next      = S_ALUWB;
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      S_ADDIEX: begin
        w_next      = S_ADDIWB;
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: begin
        w_next = S_FETCH;  // encodings 12..15 recover with no side effects
      end
    endcase
  end

  // ALU decoder
  always_comb begin
    w_alu_control = 3'b010;
    case (w_alu_op)
      2'b01: w_alu_control = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'h22:   w_alu_control = 3'b110;
          6'h24:   w_alu_control = 3'b000;
          6'h25:   w_alu_control = 3'b001;
          6'h2A:   w_alu_control = 3'b111;
          default: w_alu_control = 3'b010;
        endcase
      end
      default: w_alu_control = 3'b010;
    endcase
  end

  assign bus.iord        = w_iord;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_control = w_alu_control;
  assign bus.state       = w_cur;

  // The edge that samples rst=1 must not commit any architectural write.
  assign bus.mem_write   = w_mem_write & ~rst;
  assign bus.ir_write    = w_ir_write  & ~rst;
  assign bus.reg_write   = w_reg_write & ~rst;
  assign bus.pc_en       = (w_pc_write | (w_branch & bus.zero)) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Self-checking bench for mc_ctrl. A reference model expands
//                each opcode into its expected state walk and per-state
//                control word; randomized instructions, zero flags and
//                mid-instruction resets are compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed control word:
  // {iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b[1:0],pc_src[1:0],alu_control[2:0],pc_en,state[3:0]}
  function automatic logic [31:0] observed();
    return {13'd0, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.pc_src, bus.alu_control, bus.pc_en, bus.state};
  endfunction

  function automatic logic [2:0] ref_alu(input int alu_op, input logic [5:0] f);
    if (alu_op == 1) return 3'b110;
    if (alu_op == 2) begin
      if (f == 6'h22) return 3'b110;
      if (f == 6'h24) return 3'b000;
      if (f == 6'h25) return 3'b001;
      if (f == 6'h2A) return 3'b111;
    end
    return 3'b010;
  endfunction

  // Expected control word for a given step of the instruction walk.
  function automatic logic [31:0] model_out(input int s, input logic [5:0] f,
                                            input logic z, input logic r);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
    logic pcw = 0, br = 0;
    logic [1:0] sb = 0, ps = 0;
    int aop = 0;
    int st = r ? 0 : s;
    case (st)
      0:    begin sb = 2'b01; irw = 1; pcw = 1; end
      1:    sb = 2'b11;
      2, 9: begin sa = 1; sb = 2'b10; end
      3:    iord = 1;
      4:    begin m2r = 1; rw = 1; end
      5:    begin iord = 1; mw = 1; end
      6:    begin sa = 1; aop = 2; end
      7:    begin rd = 1; rw = 1; end
      8:    begin sa = 1; aop = 1; ps = 2'b01; br = 1; end
      10:   rw = 1;
      11:   begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (r) begin irw = 0; pcw = 0; end
    return {13'd0, iord, mw & ~r, irw, rd, m2r, rw & ~r, sa, sb, ps,
            ref_alu(aop, f), pcw | (br & z & ~r), st[3:0]};
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
  endfunction

  // Runs one instruction; zmode<0 randomizes zero each cycle.
  // abort_at>=0 asserts rst during that step of the walk.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int zmode, input int abort_at);
    int seq[$];
    int nmw = 0;
    int nrw = 0;
    int exp_mw, exp_rw;
    case (op)
      6'h23:   seq = '{0, 1, 2, 3, 4};
      6'h2B:   seq = '{0, 1, 2, 5};
      6'h00:   seq = '{0, 1, 6, 7};
      6'h04:   seq = '{0, 1, 8};
      6'h08:   seq = '{0, 1, 9, 10};
      6'h02:   seq = '{0, 1, 11};
      default: seq = '{0, 1};
    endcase
    exp_mw = (op == 6'h2B) ? 1 : 0;
    exp_rw = (op == 6'h23 || op == 6'h00 || op == 6'h08) ? 1 : 0;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      bus.op    = op;
      bus.funct = f;
      bus.zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check($sformatf("abort op%02h step%0d", op, i), observed(),
              model_out(seq[i], f, bus.zero, 1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("state after abort", 32'(bus.state), 32'd0);
        return;
      end
      #1;
      check($sformatf("op%02h fn%02h step%0d", op, f, i), observed(),
            model_out(seq[i], f, bus.zero, 1'b0));
      nmw += int'(bus.mem_write);
      nrw += int'(bus.reg_write);
    end
    check($sformatf("mem_write count op%02h", op), 32'(nmw), 32'(exp_mw));
    check($sformatf("reg_write count op%02h", op), 32'(nrw), 32'(exp_rw));
  endtask

  logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
  logic [5:0] op_tab [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};

  initial begin
    logic [5:0] op, f;
    int ab;
    bus.op    = 6'h23;
    bus.funct = 6'h00;
    bus.zero  = 1'b0;

    // Reset held for three cycles with a lw opcode presented.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("reset", observed(), model_out(0, 6'h00, 1'b0, 1'b1));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed walks.
    run_instr(6'h23, 6'h00, -1, -1);
    run_instr(6'h2B, 6'h00, -1, -1);
    for (int k = 0; k < 6; k++) run_instr(6'h00, fn_tab[k], -1, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h08, 6'h00, -1, -1);
    run_instr(6'h02, 6'h00, -1, -1);
    run_instr(6'h3F, 6'h00, -1, -1);
    run_instr(6'h2B, 6'h00, -1, 3);   // reset lands in MEMWR
    run_instr(6'h23, 6'h00, -1, -1);

    // Randomized instruction stream with occasional aborts.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        do op = 6'($urandom_range(0, 63)); while (legal_op(op));
      end else begin
        op = op_tab[$urandom_range(0, 5)];
      end
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                       : fn_tab[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, f, -1, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Main control unit for the multicycle MIPS core. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback, driving the mux selects and write enables of the shared-memory multicycle datapath. It also contains the ALU decoder. It replaces the single-cycle combinational controller, so one unified instruction/data memory and one ALU serve every step.

## Interface
Parameters:
- none (opcode and funct encodings are fixed MIPS values)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, combinational, same cycle
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load enable
- reg_dst  output  1  destination register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  register writeback select: 0 = ALUOut, 1 = Data register
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pc_src  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alu_control  output  3  ALU operation
- pc_en  output  1  PC load enable = pc_write | (branch & zero)
- state  output  4  current state, for debug and verification

## Operation
States (encoding):
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
- Encodings 12–15 are illegal. From an illegal state the next state is FETCH and all write enables are 0.

Transitions:
- FETCH→DECODE, unconditional.
- DECODE dispatches on op:
  - 0x23 lw → MEMADR
  - 0x2B sw → MEMADR
  - 0x00 R-type → EXEC
  - 0x04 beq → BRANCH
  - 0x08 addi → ADDIEX
  - 0x02 j → JUMP
  - any other op → FETCH; the instruction is a NOP and no write occurs.
- MEMADR → MEMRD if op = 0x23, otherwise MEMWR.
- MEMRD→MEMWB, EXEC→ALUWB, ADDIEX→ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP each → FETCH.

Per-state outputs (every output not listed is 0):
- FETCH: alu_src_b=01, alu_op=00, ir_write=1, pc_write=1
- DECODE: alu_src_b=11, alu_op=00
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00
- MEMRD: iord=1
- MEMWR: iord=1, mem_write=1
- MEMWB: mem_to_reg=1, reg_write=1
- EXEC: alu_src_a=1, alu_op=10
- ALUWB: reg_dst=1, reg_write=1
- ADDIWB: reg_write=1
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1
- JUMP: pc_src=10, pc_write=1

ALU decoder (combinational):
- alu_op 00 → 010 (add)
- alu_op 01 → 110 (sub)
- alu_op 10 decodes funct:
  - 0x20 → 010
  - 0x22 → 110
  - 0x24 → 000
  - 0x25 → 001
  - 0x2A → 111
  - any other funct → 010
- alu_op 11 is unused → 010

## Timing
- State register: synchronous. When rst=1 at a rising edge, state becomes FETCH.
- All outputs are combinational from state; pc_en additionally depends on zero.
- While rst=1, pc_en, ir_write, reg_write and mem_write are forced to 0. The remaining outputs show their FETCH values: alu_src_b=01, alu_control=010, everything else 0. state reads 0.
- Reset asserted mid-instruction aborts that instruction. The edge that samples rst=1 performs no write. The first real fetch happens in the first cycle after rst drops.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unknown op 2
- In BRANCH, pc_en equals zero in that same cycle. In all states other than FETCH, BRANCH and JUMP, pc_en is 0.
- mem_write is high for exactly one cycle per sw. reg_write is high for exactly one cycle per lw, R-type and addi.

## Test plan
- Reset: hold rst=1 for 3 cycles with op=0x23 → state stays 0 and all enables are 0. After release, cycle 1 has ir_write=1, pc_en=1, alu_src_b=01.
- lw, op=0x23: state sequence 0,1,2,3,4,0. In state 4, reg_write=1, mem_to_reg=1, reg_dst=0. iord=1 in states 3 only.
- sw, op=0x2B: sequence 0,1,2,5,0. mem_write=1 only in state 5. reg_write is never 1.
- R-type, op=0: sweep funct 0x20, 0x22, 0x24, 0x25, 0x2A, 0x3F. In EXEC, alu_control is 010, 110, 000, 001, 111, 010 respectively. ALUWB has reg_dst=1.
- beq, op=0x04:
  - zero=1 in BRANCH → pc_en=1, pc_src=01, alu_control=110.
  - zero=0 → pc_en=0.
  - j, op=0x02: sequence 0,1,11,0 with pc_src=10 and pc_en=1 in JUMP.
- Corner cases:
  - op=0x3F in DECODE → next state 0 with no write enable asserted.
  - rst=1 asserted while in MEMWR → no mem_write at that edge; next state 0.
